// File: rtl/rr_arbiter_1hot_if.sv
// Handshake bundle between the round-robin arbiter and its requesters / downstream consumer.
// The master side is the arbiter; the slave side is whatever drives req and out_ready.
interface rr_arbiter_1hot_if #(
  parameter int unsigned SIZE = 3
) ();

  logic [SIZE-1:0] req;
  logic [SIZE-1:0] in_ready;
  logic [SIZE-1:0] sel;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            err;

  modport master (
    input  req,
    input  out_ready,
    output in_ready,
    output sel,
    output out_valid,
    output busy,
    output err
  );

  modport slave (
    output req,
    output out_ready,
    input  in_ready,
    input  sel,
    input  out_valid,
    input  busy,
    input  err
  );

endinterface

// File: rtl/rr_arbiter_1hot.sv
// Round-robin arbiter producing a registered one-hot select for a downstream one-hot mux.
// Each grant is held until a valid/ready handshake or until the winner withdraws its request.
module rr_arbiter_1hot #(
  parameter int unsigned SIZE = 3
) (
  input logic               clk,
  input logic               reset,
  rr_arbiter_1hot_if.master bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [SIZE-1:0] sel_q;
  logic [SIZE-1:0] ptr_q;
  logic            out_valid_q;
  logic            err_q;

  logic [SIZE-1:0] winner;
  logic [SIZE-1:0] sel_rot;
  logic            found;
  logic            handshake;
  logic            withdrawn;
  int unsigned     ptr_idx;
  int unsigned     scan_idx;

  always_comb begin
    ptr_idx = 0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (ptr_q[i]) ptr_idx = i;
    end
  end

  // First set request scanning upward from the pointer, wrapping to 0.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      scan_idx = (ptr_idx + i) % SIZE;
      if (!found && bus.req[scan_idx]) begin
        winner[scan_idx] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  assign sel_rot   = {sel_q[SIZE-2:0], sel_q[SIZE-1]};
  assign handshake = out_valid_q & bus.out_ready;
  assign withdrawn = ~|(bus.req & sel_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      ptr_q       <= SIZE'(1);
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            sel_q       <= winner;
            out_valid_q <= 1'b1;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          // A handshake in the same cycle as a withdrawal still counts as a clean transfer.
          if (handshake) begin
            ptr_q       <= sel_rot;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else if (withdrawn) begin
            err_q       <= 1'b1;
            ptr_q       <= sel_rot;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == StGrant);
  assign bus.err       = err_q;
  assign bus.in_ready  = (state_q == StGrant) ? (sel_q & {SIZE{bus.out_ready}}) : '0;

  a_sel_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(sel_q));
  a_ir_onehot0  : assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.in_ready));
  a_valid_sel   : assert property (@(posedge clk) disable iff (!reset)
                                   out_valid_q == (sel_q != '0));
  a_grant_sel   : assert property (@(posedge clk) disable iff (!reset)
                                   (state_q == StGrant) |-> (sel_q != '0));

endmodule

// File: tb/tb_rr_arbiter_1hot.sv
// Self-checking bench: directed vector table for the listed scenarios, then randomized
// traffic compared against an index-based behavioural model of the arbiter.
module tb_rr_arbiter_1hot;

  localparam int unsigned SIZE = 3;
  localparam int NVEC = 34;
  localparam int NRAND = 1500;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic       ordy;
    logic       chk;
    logic [2:0] sel;
    logic       ov;
    logic [2:0] ir;
    logic       err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  // Model state: granted index (-1 when idle), priority index, sticky error.
  int   m_g;
  int   m_p;
  bit   m_err;

  vec_t tbl [NVEC];

  rr_arbiter_1hot_if #(.SIZE(SIZE)) bus ();

  rr_arbiter_1hot #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream Mux1hot3 with in0=000, in1=001, in2=010.
  function automatic logic [2:0] mux3(input logic [2:0] s);
    return ({3{s[0]}} & 3'b000) | ({3{s[1]}} & 3'b001) | ({3{s[2]}} & 3'b010);
  endfunction

  function automatic vec_t v(input logic rst, input logic [2:0] req, input logic ordy,
                             input logic chk, input logic [2:0] sel, input logic ov,
                             input logic [2:0] ir, input logic err);
    vec_t r;
    r.rst = rst; r.req = req; r.ordy = ordy; r.chk = chk;
    r.sel = sel; r.ov = ov; r.ir = ir; r.err = err;
    return r;
  endfunction

  task automatic apply(input logic rst, input logic [2:0] rq, input logic ordy);
    @(negedge clk);
    reset         = rst;
    bus.req       = rq;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic model_tick(input logic rst, input logic [2:0] rq, input logic ordy);
    bit fnd;
    int c;
    if (!rst) begin
      m_g   = -1;
      m_p   = 0;
      m_err = 1'b0;
    end else if (m_g < 0) begin
      fnd = 1'b0;
      for (int k = 0; k < 3; k++) begin
        c = (m_p + k) % 3;
        if (!fnd && rq[c]) begin
          m_g = c;
          fnd = 1'b1;
        end
      end
    end else if (ordy) begin
      m_p = (m_g + 1) % 3;
      m_g = -1;
    end else if (!rq[m_g]) begin
      m_err = 1'b1;
      m_p   = (m_g + 1) % 3;
      m_g   = -1;
    end
  endtask

  task automatic tick(input logic rst, input logic [2:0] rq, input logic ordy);
    @(posedge clk);
    model_tick(rst, rq, ordy);
  endtask

  task automatic check(input string name, input logic [2:0] esel, input logic eov,
                       input logic [2:0] eir, input logic eerr);
    logic [11:0] act;
    logic [11:0] exp;
    act = {bus.sel, bus.out_valid, bus.in_ready, bus.err, bus.busy, mux3(bus.sel)};
    exp = {esel, eov, eir, eerr, eov, mux3(esel)};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got sel=%b valid=%b in_ready=%b err=%b busy=%b mux=%b, want sel=%b valid=%b in_ready=%b err=%b busy=%b mux=%b",
                  name, act[11:9], act[8], act[7:5], act[4], act[3], act[2:0],
                  exp[11:9], exp[8], exp[7:5], exp[4], exp[3], exp[2:0]);
  endtask

  initial begin
    logic       r_rst;
    logic [2:0] r_req;
    logic       r_ordy;
    logic [2:0] e_sel;
    logic [2:0] e_ir;

    n_pass = 0;
    n_total = 0;
    m_g = -1;
    m_p = 0;
    m_err = 1'b0;
    reset = 1'b0;
    bus.req = '0;
    bus.out_ready = 1'b0;

    // Reset held with all requests raised
    tbl[0]  = v(0, 3'b111, 0, 0, 3'b000, 0, 3'b000, 0);
    tbl[1]  = v(0, 3'b111, 0, 1, 3'b000, 0, 3'b000, 0);
    // Single request, one-cycle latency, then bubble
    tbl[2]  = v(1, 3'b010, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[3]  = v(1, 3'b010, 1, 1, 3'b010, 1, 3'b010, 0);
    tbl[4]  = v(1, 3'b000, 1, 1, 3'b000, 0, 3'b000, 0);
    // Fresh reset, then all requesters held: 001,010,100,001 with bubbles
    tbl[5]  = v(0, 3'b000, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[6]  = v(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[7]  = v(1, 3'b111, 1, 1, 3'b001, 1, 3'b001, 0);
    tbl[8]  = v(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[9]  = v(1, 3'b111, 1, 1, 3'b010, 1, 3'b010, 0);
    tbl[10] = v(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[11] = v(1, 3'b111, 1, 1, 3'b100, 1, 3'b100, 0);
    tbl[12] = v(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[13] = v(1, 3'b111, 1, 1, 3'b001, 1, 3'b001, 0);
    // Backpressure for 5 cycles, then exactly one in_ready pulse
    tbl[14] = v(1, 3'b100, 0, 1, 3'b000, 0, 3'b000, 0);
    tbl[15] = v(1, 3'b100, 0, 1, 3'b100, 1, 3'b000, 0);
    tbl[16] = v(1, 3'b100, 0, 1, 3'b100, 1, 3'b000, 0);
    tbl[17] = v(1, 3'b100, 0, 1, 3'b100, 1, 3'b000, 0);
    tbl[18] = v(1, 3'b100, 0, 1, 3'b100, 1, 3'b000, 0);
    tbl[19] = v(1, 3'b100, 0, 1, 3'b100, 1, 3'b000, 0);
    tbl[20] = v(1, 3'b100, 1, 1, 3'b100, 1, 3'b100, 0);
    tbl[21] = v(1, 3'b000, 1, 1, 3'b000, 0, 3'b000, 0);
    // Withdrawal sets sticky err; next grant on 111 is 100
    tbl[22] = v(1, 3'b010, 0, 1, 3'b000, 0, 3'b000, 0);
    tbl[23] = v(1, 3'b000, 0, 1, 3'b010, 1, 3'b000, 0);
    tbl[24] = v(1, 3'b111, 0, 1, 3'b000, 0, 3'b000, 1);
    tbl[25] = v(1, 3'b111, 1, 1, 3'b100, 1, 3'b100, 1);
    tbl[26] = v(1, 3'b000, 1, 1, 3'b000, 0, 3'b000, 1);
    // Reset during GRANT with sel=100, req=111
    tbl[27] = v(1, 3'b100, 0, 1, 3'b000, 0, 3'b000, 1);
    tbl[28] = v(1, 3'b111, 0, 1, 3'b100, 1, 3'b000, 1);
    tbl[29] = v(0, 3'b111, 1, 1, 3'b100, 1, 3'b100, 1);
    tbl[30] = v(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 0);
    // Withdrawal coinciding with handshake: no error
    tbl[31] = v(1, 3'b111, 0, 1, 3'b001, 1, 3'b000, 0);
    tbl[32] = v(1, 3'b000, 1, 1, 3'b001, 1, 3'b001, 0);
    tbl[33] = v(1, 3'b000, 0, 1, 3'b000, 0, 3'b000, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].ordy);
      if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].ov, tbl[i].ir, tbl[i].err);
      tick(tbl[i].rst, tbl[i].req, tbl[i].ordy);
    end

    // Start random traffic from a known reset point.
    apply(1'b0, 3'b000, 1'b0);
    tick(1'b0, 3'b000, 1'b0);

    for (int i = 0; i < NRAND; i++) begin
      r_rst  = ($urandom_range(0, 63) != 0);
      r_req  = 3'($urandom_range(0, 7));
      r_ordy = ($urandom_range(0, 99) < 55);
      apply(r_rst, r_req, r_ordy);
      e_sel = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
      e_ir  = r_ordy ? e_sel : 3'b000;
      check($sformatf("rand%0d", i), e_sel, (m_g >= 0), e_ir, m_err);
      tick(r_rst, r_req, r_ordy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
